// File: rtl/furv_lsu.sv
// Load/store unit: drives a word-addressed bus, splits lane-crossing accesses
// into two beats and assembles/extends load data.
//
// state | meaning
// IDLE  | waiting for req; captures the access
// BEAT0 | first bus beat, lanes from the address offset upward
// BEAT1 | second beat of a split access, next bus word
// DONE  | one-cycle completion pulse, fault qualifies it
module furv_lsu #(
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int TIMEOUT          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [1:0]                   width,
  input  logic                         unsigned_ld,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         fault,
  output logic [31:0]                  rdata,
  output logic                         mem,
  output logic                         mem_write,
  output logic [31-$clog2(DATA_W/8):0] bus_addr,
  output logic [DATA_W/8-1:0]          sel,
  output logic [DATA_W-1:0]            data_out,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         ack
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int AW    = 32 - OFS;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic              uns_q;
  logic              split_q;
  logic [1:0]        width_q;
  logic [OFS-1:0]    ofs_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] ld_lo;
  logic [TW-1:0]     cnt;

  logic [1:0]          cur_width;
  logic [31:0]         cur_wdata;
  logic [OFS-1:0]      ofs;
  logic [3:0]          size_mask;
  logic [3:0]          lane_end;
  logic                split;
  logic [2*BYTES-1:0]  lane_mask;
  logic [2*DATA_W-1:0] st_wide;
  logic [2*DATA_W-1:0] ld_wide;
  logic [31:0]         ld_raw;
  logic [31:0]         ld_ext;
  logic                to_hit;

  // In IDLE the lane math looks at the live request; afterwards at the capture.
  always_comb begin
    cur_width = (state == IDLE) ? width : width_q;
    cur_wdata = (state == IDLE) ? wdata : wdata_q;
    ofs       = (state == IDLE) ? addr[OFS-1:0] : ofs_q;
    case (cur_width)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    case (cur_width)
      2'd0:    lane_end = 4'(ofs) + 4'd1;
      2'd1:    lane_end = 4'(ofs) + 4'd2;
      default: lane_end = 4'(ofs) + 4'd4;
    endcase
    split     = lane_end > 4'(BYTES);
    lane_mask = {{(2*BYTES-4){1'b0}}, size_mask} << ofs;
    st_wide   = {{(2*DATA_W-32){1'b0}}, cur_wdata} << {ofs, 3'b000};
    ld_wide   = (state == BEAT1) ? {data_in, ld_lo} : {{DATA_W{1'b0}}, data_in};
    ld_raw    = 32'(ld_wide >> {ofs, 3'b000});
    case (width_q)
      2'd0:    ld_ext = uns_q ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
      2'd1:    ld_ext = uns_q ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
    to_hit = (TIMEOUT != 0) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      split_q   <= 1'b0;
      width_q   <= 2'd0;
      ofs_q     <= '0;
      wdata_q   <= 32'd0;
      ld_lo     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      mem       <= 1'b0;
      mem_write <= 1'b0;
      bus_addr  <= '0;
      sel       <= '0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            uns_q   <= unsigned_ld;
            width_q <= width;
            ofs_q   <= addr[OFS-1:0];
            wdata_q <= wdata;
            split_q <= split;
            if (split && (ALLOW_MISALIGNED == 0)) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= BEAT0;
              busy      <= 1'b1;
              mem       <= 1'b1;
              mem_write <= we;
              bus_addr  <= addr[31:OFS];
              sel       <= lane_mask[BYTES-1:0];
              data_out  <= st_wide[DATA_W-1:0];
              cnt       <= TO_LOAD;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (ack) begin
            if ((state == BEAT0) && split_q) begin
              state    <= BEAT1;
              bus_addr <= bus_addr + AW'(1);
              sel      <= lane_mask[2*BYTES-1:BYTES];
              data_out <= st_wide[2*DATA_W-1:DATA_W];
              ld_lo    <= data_in;
              cnt      <= TO_LOAD;
            end else begin
              state     <= DONE;
              busy      <= 1'b0;
              mem       <= 1'b0;
              mem_write <= 1'b0;
              sel       <= '0;
              done      <= 1'b1;
              fault     <= 1'b0;
              if (!we_q) rdata <= ld_ext;
            end
          end else if (to_hit) begin
            // Ack on the terminal cycle is taken above, so it beats the timeout.
            state     <= DONE;
            busy      <= 1'b0;
            mem       <= 1'b0;
            mem_write <= 1'b0;
            sel       <= '0;
            done      <= 1'b1;
            fault     <= 1'b1;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_furv_lsu.sv
// Directed bench for furv_lsu: 32-bit unit with timeout, 32-bit unit that faults
// misaligned accesses, and a 64-bit unit.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: got %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_furv_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_a, req_b, req_c;
  logic        we, unsigned_ld;
  logic [1:0]  width;
  logic [31:0] addr, wdata;
  logic        ack_a, ack_b, ack_c;
  logic [31:0] din_a, din_b;
  logic [63:0] din_c;

  logic        busy_a, done_a, fault_a, mem_a, mem_write_a;
  logic [31:0] rdata_a, data_out_a;
  logic [29:0] bus_addr_a;
  logic [3:0]  sel_a;

  logic        busy_b, done_b, fault_b, mem_b, mem_write_b;
  logic [31:0] rdata_b, data_out_b;
  logic [29:0] bus_addr_b;
  logic [3:0]  sel_b;

  logic        busy_c, done_c, fault_c, mem_c, mem_write_c;
  logic [31:0] rdata_c;
  logic [63:0] data_out_c;
  logic [28:0] bus_addr_c;
  logic [7:0]  sel_c;

  int checks = 0;
  int errors = 0;

  furv_lsu #(.DATA_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .width(width), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .busy(busy_a), .done(done_a), .fault(fault_a),
    .rdata(rdata_a), .mem(mem_a), .mem_write(mem_write_a), .bus_addr(bus_addr_a),
    .sel(sel_a), .data_out(data_out_a), .data_in(din_a), .ack(ack_a));

  furv_lsu #(.DATA_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .width(width), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .busy(busy_b), .done(done_b), .fault(fault_b),
    .rdata(rdata_b), .mem(mem_b), .mem_write(mem_write_b), .bus_addr(bus_addr_b),
    .sel(sel_b), .data_out(data_out_b), .data_in(din_b), .ack(ack_b));

  furv_lsu #(.DATA_W(64), .ALLOW_MISALIGNED(1), .TIMEOUT(0)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .we(we), .width(width), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .busy(busy_c), .done(done_c), .fault(fault_c),
    .rdata(rdata_c), .mem(mem_c), .mem_write(mem_write_c), .bus_addr(bus_addr_c),
    .sel(sel_c), .data_out(data_out_c), .data_in(din_c), .ack(ack_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_a = 0; req_b = 0; req_c = 0;
    we = 0; width = 0; unsigned_ld = 0; addr = 0; wdata = 0;
    ack_a = 0; ack_b = 0; ack_c = 0;
    din_a = 0; din_b = 0; din_c = 0;

    // asynchronous reset, checked before any clock edge
    #1 rst = 1;
    #1;
    `CHK("rst_mem", mem_a, 1'b0)
    `CHK("rst_busy", busy_a, 1'b0)
    `CHK("rst_done", done_a, 1'b0)
    `CHK("rst_fault", fault_a, 1'b0)
    `CHK("rst_rdata", rdata_a, 32'h0)
    `CHK("rst_sel", sel_a, 4'h0)
    `CHK("rst_bus_addr", bus_addr_a, 30'h0)
    `CHK("rst_data_out", data_out_a, 32'h0)
    `CHK("rst_mem_write", mem_write_a, 1'b0)
    tick(); tick();
    rst = 0;

    // signed byte load from lane 3
    we = 0; width = 0; unsigned_ld = 0; addr = 32'h103; req_a = 1;
    tick(); req_a = 0;
    `CHK("lb_mem", mem_a, 1'b1)
    `CHK("lb_busy", busy_a, 1'b1)
    `CHK("lb_sel", sel_a, 4'b1000)
    `CHK("lb_bus_addr", bus_addr_a, 30'h40)
    `CHK("lb_mem_write", mem_write_a, 1'b0)
    `CHK("lb_done_early", done_a, 1'b0)
    din_a = 32'h80FF_FFFF; ack_a = 1;
    tick(); ack_a = 0;
    `CHK("lb_done", done_a, 1'b1)
    `CHK("lb_fault", fault_a, 1'b0)
    `CHK("lb_rdata", rdata_a, 32'hFFFF_FF80)
    `CHK("lb_mem_drop", mem_a, 1'b0)
    tick();
    `CHK("lb_done_pulse", done_a, 1'b0)

    // split word store across 0x100/0x104
    we = 1; width = 2; addr = 32'h102; wdata = 32'hAABB_CCDD; req_a = 1;
    tick(); req_a = 0;
    `CHK("sw_b0_sel", sel_a, 4'b1100)
    `CHK("sw_b0_data", data_out_a[31:16], 16'hCCDD)
    `CHK("sw_b0_bus_addr", bus_addr_a, 30'h40)
    `CHK("sw_b0_mem_write", mem_write_a, 1'b1)
    ack_a = 1;
    tick();
    `CHK("sw_b1_bus_addr", bus_addr_a, 30'h41)
    `CHK("sw_b1_sel", sel_a, 4'b0011)
    `CHK("sw_b1_data", data_out_a[15:0], 16'hAABB)
    `CHK("sw_b1_mem", mem_a, 1'b1)
    `CHK("sw_b1_done_early", done_a, 1'b0)
    tick(); ack_a = 0;
    `CHK("sw_done", done_a, 1'b1)
    `CHK("sw_fault", fault_a, 1'b0)
    `CHK("sw_mem_drop", mem_a, 1'b0)
    `CHK("sw_rdata_held", rdata_a, 32'hFFFF_FF80)
    tick();

    // same store on the unit that faults misaligned accesses
    req_b = 1;
    tick(); req_b = 0;
    `CHK("mis_done", done_b, 1'b1)
    `CHK("mis_fault", fault_b, 1'b1)
    `CHK("mis_no_mem", mem_b, 1'b0)
    tick();
    `CHK("mis_done_pulse", done_b, 1'b0)
    `CHK("mis_no_mem2", mem_b, 1'b0)

    // 64-bit unit: half load from lanes 7:6
    we = 0; width = 1; unsigned_ld = 1; addr = 32'h6; req_c = 1;
    tick(); req_c = 0;
    `CHK("w64_sel", sel_c, 8'hC0)
    `CHK("w64_bus_addr", bus_addr_c, 29'h0)
    `CHK("w64_mem", mem_c, 1'b1)
    din_c = 64'h8001_0000_0000_0000; ack_c = 1;
    tick(); ack_c = 0;
    `CHK("w64_done", done_c, 1'b1)
    `CHK("w64_fault", fault_c, 1'b0)
    `CHK("w64_single_beat", mem_c, 1'b0)
    `CHK("w64_rdata_zext", rdata_c, 32'h0000_8001)
    tick();
    unsigned_ld = 0; req_c = 1;
    tick(); req_c = 0; ack_c = 1;
    tick(); ack_c = 0;
    `CHK("w64_done_s", done_c, 1'b1)
    `CHK("w64_rdata_sext", rdata_c, 32'hFFFF_8001)
    tick();

    // split signed word load
    we = 0; width = 2; unsigned_ld = 0; addr = 32'hFE; req_a = 1;
    tick(); req_a = 0;
    `CHK("lw_b0_sel", sel_a, 4'b1100)
    `CHK("lw_b0_bus_addr", bus_addr_a, 30'h3F)
    din_a = 32'h1234_5678; ack_a = 1;
    tick();
    `CHK("lw_b1_sel", sel_a, 4'b0011)
    `CHK("lw_b1_bus_addr", bus_addr_a, 30'h40)
    `CHK("lw_b1_done_early", done_a, 1'b0)
    din_a = 32'h9ABC_DEF0;
    tick(); ack_a = 0;
    `CHK("lw_done", done_a, 1'b1)
    `CHK("lw_rdata", rdata_a, 32'hDEF0_1234)
    tick();

    // split signed half load
    width = 1; addr = 32'h103; req_a = 1;
    tick(); req_a = 0;
    `CHK("lh_b0_sel", sel_a, 4'b1000)
    din_a = 32'hCD00_0000; ack_a = 1;
    tick();
    `CHK("lh_b1_sel", sel_a, 4'b0001)
    `CHK("lh_b1_bus_addr", bus_addr_a, 30'h41)
    din_a = 32'h0000_00AB;
    tick(); ack_a = 0;
    `CHK("lh_done", done_a, 1'b1)
    `CHK("lh_rdata", rdata_a, 32'hFFFF_ABCD)
    tick();

    // second beat wraps the bus word address
    we = 1; width = 2; addr = 32'hFFFF_FFFE; wdata = 32'h0102_0304; req_a = 1;
    tick(); req_a = 0;
    `CHK("wrap_b0_bus_addr", bus_addr_a, 30'h3FFF_FFFF)
    ack_a = 1;
    tick();
    `CHK("wrap_b1_bus_addr", bus_addr_a, 30'h0)
    `CHK("wrap_b1_sel", sel_a, 4'b0011)
    tick(); ack_a = 0;
    `CHK("wrap_done", done_a, 1'b1)
    tick();

    // timeout: mem high for four cycles, then faulted completion
    we = 0; width = 2; addr = 32'h200; req_a = 1;
    tick(); req_a = 0;
    `CHK("to_mem_c1", mem_a, 1'b1)
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if (mem_a !== 1'b1) begin
        errors++;
        $error("FAIL to_mem_hold cycle %0d: got %0h expected 1", i, mem_a);
      end
      checks++;
      if (done_a !== 1'b0) begin
        errors++;
        $error("FAIL to_no_done cycle %0d: got %0h expected 0", i, done_a);
      end
    end
    tick();
    `CHK("to_done", done_a, 1'b1)
    `CHK("to_fault", fault_a, 1'b1)
    `CHK("to_mem_drop", mem_a, 1'b0)
    `CHK("to_rdata_held", rdata_a, 32'hFFFF_ABCD)
    tick();
    `CHK("to_done_pulse", done_a, 1'b0)
    `CHK("to_fault_clear", fault_a, 1'b0)

    // ack on the terminal cycle wins; req held while busy is ignored
    addr = 32'h204; req_a = 1;
    tick();
    addr = 32'h300;
    tick(); tick(); tick();
    req_a = 0; din_a = 32'h1122_3344; ack_a = 1;
    tick(); ack_a = 0;
    `CHK("aw_done", done_a, 1'b1)
    `CHK("aw_fault", fault_a, 1'b0)
    `CHK("aw_rdata", rdata_a, 32'h1122_3344)
    tick(); tick();
    `CHK("nq_mem", mem_a, 1'b0)
    `CHK("nq_busy", busy_a, 1'b0)
    `CHK("nq_done", done_a, 1'b0)

    // reset while in the second beat
    we = 1; width = 2; addr = 32'h102; wdata = 32'hAABB_CCDD; req_a = 1;
    tick(); req_a = 0; ack_a = 1;
    tick(); ack_a = 0;
    `CHK("rb1_mem", mem_a, 1'b1)
    `CHK("rb1_bus_addr", bus_addr_a, 30'h41)
    #2 rst = 1; ack_a = 1;
    #1;
    `CHK("rb1_mem_async", mem_a, 1'b0)
    `CHK("rb1_busy_async", busy_a, 1'b0)
    `CHK("rb1_sel_async", sel_a, 4'h0)
    `CHK("rb1_rdata_clr", rdata_a, 32'h0)
    tick();
    `CHK("rb1_no_done", done_a, 1'b0)
    `CHK("rb1_mem_rst", mem_a, 1'b0)
    rst = 0;
    tick(); ack_a = 0;
    `CHK("rb1_no_done2", done_a, 1'b0)
    `CHK("rb1_idle_mem", mem_a, 1'b0)

    // next access after reset completes normally
    we = 0; width = 0; unsigned_ld = 1; addr = 32'h100; req_a = 1;
    tick(); req_a = 0;
    `CHK("post_sel", sel_a, 4'b0001)
    din_a = 32'h0000_00FF; ack_a = 1;
    tick(); ack_a = 0;
    `CHK("post_done", done_a, 1'b1)
    `CHK("post_fault", fault_a, 1'b0)
    `CHK("post_rdata", rdata_a, 32'h0000_00FF)
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/furv_lsu.md
FURV_LSU -- requirements
Module: furv_lsu

Interface
REQ-001 Parameter DATA_W, default 32, bus data width in bits; legal values 32 or 64; BYTES = DATA_W/8, OFS = log2(BYTES).
REQ-002 Parameter ALLOW_MISALIGNED, default 1; 1 = split boundary-crossing accesses into two beats, 0 = fault them.
REQ-003 Parameter TIMEOUT, default 0, wait cycles per beat before fault; 0 disables timeout.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req  in  1  start access; sampled only in IDLE.
REQ-008 we  in  1  1 = store, 0 = load.
REQ-009 width  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-010 unsigned_ld  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 addr  in  32  byte address.
REQ-012 wdata  in  32  store data, right-aligned.
REQ-013 busy  out  1  high from the cycle after an accepted req until done.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 fault  out  1  valid with done; 1 = misaligned (ALLOW_MISALIGNED=0) or timeout.
REQ-016 rdata  out  32  extended load result, valid with done, held until next done.
REQ-017 mem  out  1  bus cycle active.
REQ-018 mem_write  out  1  bus write strobe, meaningful only while mem=1.
REQ-019 bus_addr  out  32-OFS  bus word address.
REQ-020 sel  out  BYTES  byte lane enables.
REQ-021 data_out  out  DATA_W  lane-aligned store data.
REQ-022 data_in  in  DATA_W  load data, sampled when ack=1.
REQ-023 ack  in  1  beat completion, honoured only while mem=1.

Function
REQ-024 FSM states IDLE, BEAT0, BEAT1, DONE.
REQ-025 IDLE: req=1 captures we/width/unsigned_ld/addr/wdata; if misaligned and ALLOW_MISALIGNED=0, go to DONE with fault=1 and no bus cycle; else go to BEAT0.
REQ-026 Misaligned means (addr mod BYTES) + size > BYTES, where size = 1, 2 or 4.
REQ-027 BEAT0: mem=1, bus_addr=addr[31:OFS], sel = lanes [ofs .. min(ofs+size, BYTES)-1], data_out = wdata shifted left by 8*ofs.
REQ-028 BEAT0 ack with split required goes to BEAT1; ack without split goes to DONE.
REQ-029 BEAT1: bus_addr = addr[31:OFS]+1, wrapping modulo 2^(32-OFS); sel = lanes [0 .. ofs+size-BYTES-1], carrying the remaining upper bytes of wdata.
REQ-030 Loads: bytes captured from data_in lanes on each ack, assembled low-byte-first, then sign- or zero-extended from size into rdata.
REQ-031 mem, mem_write, sel and bus_addr hold stable while waiting for ack; mem drops in the cycle after the final ack.
REQ-032 Timeout: a per-beat counter resets on beat entry; when TIMEOUT>0 and the counter reaches TIMEOUT with no ack, mem drops and the FSM goes to DONE with fault=1 and rdata unchanged.
REQ-033 Ack in the same cycle the counter hits TIMEOUT wins; no fault.
REQ-034 DONE: done=1 for exactly one cycle, then IDLE; a new req is accepted in the IDLE cycle after done.
REQ-035 req while busy is ignored and not queued.
REQ-036 Minimum latency, req accepted to done: aligned single beat with immediate ack = 3 cycles; split = 4 cycles.

Reset
REQ-037 rst=1 immediately forces IDLE and mem=0, mem_write=0, sel=0, busy=0, done=0, fault=0, rdata=0, data_out=0, bus_addr=0, counter=0.
REQ-038 Reset mid-beat abandons the access with no done pulse; ack during or after reset is ignored.

Verification
REQ-039 DATA_W=32, load byte addr=0x103, data_in=0x80FF_FFFF, unsigned_ld=0 -> sel=1000, bus_addr=0x40, rdata=0xFFFF_FF80, fault=0.
REQ-040 DATA_W=32, store word addr=0x102, wdata=0xAABBCCDD -> beat0 sel=1100, data_out[31:16]=0xCCDD; beat1 bus_addr=0x41, sel=0011, data_out[15:0]=0xAABB.
REQ-041 Same as REQ-040 with ALLOW_MISALIGNED=0 -> no mem assertion, done=1 and fault=1 two cycles after req.
REQ-042 DATA_W=64, load half addr=0x6, data_in lanes 7:6=0x8001, unsigned_ld=1 -> sel=0xC0, single beat, rdata=0x0000_8001.
REQ-043 TIMEOUT=4 with ack held low -> mem high for 4 cycles, then done=1, fault=1, mem=0.
REQ-044 rst pulse while in BEAT1 -> mem=0 within the same cycle, no done pulse; next req completes normally.
